// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// the mux/ALU select codes also decoded by the PC-select mux and ALU control.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StTrap     = 4'd12
  } state_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_REG = 2'b00;
  localparam logic [1:0] ALU_B_ONE = 2'b01;
  localparam logic [1:0] ALU_B_IMM = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control-word decoder for the multi-cycle sequencer.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       memReady,
  input  logic       rst,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALU_B_ONE;
        ctrl.ir_write  = memReady;
        ctrl.pc_write  = memReady;
      end
      StDecode: ctrl.alu_src_b = ALU_B_IMM;
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      StAddiExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
      end
      StAddiWb: ctrl.reg_write = 1'b1;
      default: ;
    endcase
    // Reset forces FETCH asynchronously; keep every write strobe quiet while it is held.
    if (!rst) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.mem_write     = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control sequencer: state register, next-state logic and the
// sticky illegal-opcode flag; control outputs come from mc_ctrl_decode.
module mc_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zFlag,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [3:0] state,
  output logic       illegalOp
);

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  ctrl_t      ctrl;

  // Branch qualification by zFlag happens in the datapath, not here.
  logic unused_zflag;
  assign unused_zflag = zFlag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = memReady ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiExec;
          default:      state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        if (opcode == OP_LW)      state_d = StMemRead;
        else if (opcode == OP_SW) state_d = StMemWrite;
        else                      state_d = StFetch;
      end
      StMemRead:  state_d = memReady ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = memReady ? StFetch : StMemWrite;
      StExec:     state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Set on the edge that enters TRAP so the flag and the state agree in the same cycle.
  assign illegal_d = illegal_q | (state_d == StTrap);

  mc_ctrl_decode u_decode (
    .state    (state_q),
    .memReady (memReady),
    .rst      (rst),
    .ctrl     (ctrl)
  );

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign pcSource    = ctrl.pc_source;
  assign iorD        = ctrl.iord;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign irWrite     = ctrl.ir_write;
  assign memToReg    = ctrl.mem_to_reg;
  assign regDst      = ctrl.reg_dst;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign aluOp       = ctrl.alu_op;
  assign state       = state_q;
  assign illegalOp   = illegal_q;

endmodule
